// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode slice: opcodes, ALU encodings, phase bits.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package cpu_pkg;

  // Opcode field values, ir[15:12]; 9..15 are undefined.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_BEQZ = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;

  // alu_op encodings seen by the datapath.
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // Bit positions inside the one-hot sequencer phase.
  localparam int ST_FETCH  = 0;
  localparam int ST_DECODE = 1;
  localparam int ST_EXEC   = 2;
  localparam int ST_SLEEP  = 3;

  // Coarse operation class carried from decode into execute.
  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,   // NOP and every illegal opcode
    CLS_ALU  = 3'd1,
    CLS_LDI  = 3'd2,
    CLS_JMP  = 3'd3,
    CLS_BEQZ = 3'd4,
    CLS_HALT = 3'd5
  } op_cls_t;

  function automatic logic is_onehot4(input logic [3:0] s);
    return (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits ir into fields, ALU op and op class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs track ir continuously.
// Ports: ir in; alu_op, rd/rs/rt_addr, imm, imm_sel, illegal, op_cls out.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int IW = 16
) (
  input  logic [IW-1:0] ir,
  output logic [1:0]    alu_op,
  output logic [3:0]    rd_addr,
  output logic [3:0]    rs_addr,
  output logic [3:0]    rt_addr,
  output logic [7:0]    imm,
  output logic          imm_sel,
  output logic          illegal,
  output op_cls_t       op_cls
);

  logic [3:0] opcode;

  // Register and immediate fields are presented for every opcode; the
  // datapath decides which of them matter (rs/rt are don't-care for LDI).
  assign opcode  = ir[15:12];
  assign rd_addr = ir[11:8];
  assign rs_addr = ir[7:4];
  assign rt_addr = ir[3:0];
  assign imm     = ir[7:0];

  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = 1'b0;
    illegal = 1'b0;
    op_cls  = CLS_NOP;
    case (opcode)
      OP_NOP:  op_cls = CLS_NOP;
      OP_ADD:  begin op_cls = CLS_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin op_cls = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin op_cls = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:   begin op_cls = CLS_ALU; alu_op = ALU_OR;  end
      OP_LDI:  begin op_cls = CLS_LDI; imm_sel = 1'b1;   end
      OP_JMP:  op_cls = CLS_JMP;
      OP_BEQZ: op_cls = CLS_BEQZ;
      OP_HALT: op_cls = CLS_HALT;
      // Undefined opcodes run as NOP but are flagged.
      default: begin op_cls = CLS_NOP; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: holds pc and ir, registers decoded fields, steps pc.
// Latency: ir loads at end of fetch, fields at end of decode, pc at end of execute.
// Backpressure: none; the external one-hot phase paces the unit, sleep/bad phase holds state.
// Ports: clk, rst (async, active-low), state, mem_rdata, rs_zero in;
//        mem_addr, pc, ir, alu_op, rd/rs/rt_addr, imm, imm_sel, reg_we,
//        halted, illegal, state_err out.
module fetch_decode_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      state,
  input  logic [IW-1:0]   mem_rdata,
  input  logic            rs_zero,
  output logic [PC_W-1:0] mem_addr,
  output logic [PC_W-1:0] pc,
  output logic [IW-1:0]   ir,
  output logic [1:0]      alu_op,
  output logic [3:0]      rd_addr,
  output logic [3:0]      rs_addr,
  output logic [3:0]      rt_addr,
  output logic [7:0]      imm,
  output logic            imm_sel,
  output logic            reg_we,
  output logic            halted,
  output logic            illegal,
  output logic            state_err
);

  logic    onehot, active, in_fetch, in_decode, in_exec;
  op_cls_t op_cls;

  logic [1:0] dec_alu_op;
  logic [3:0] dec_rd, dec_rs, dec_rt;
  logic [7:0] dec_imm;
  logic       dec_imm_sel, dec_illegal;
  op_cls_t    dec_cls;

  // A zero or multi-hot phase behaves exactly like sleep.
  assign onehot    = is_onehot4(state);
  assign state_err = ~onehot;
  assign active    = onehot & ~state[ST_SLEEP];
  assign in_fetch  = active & state[ST_FETCH];
  assign in_decode = active & state[ST_DECODE];
  assign in_exec   = active & state[ST_EXEC];

  assign mem_addr = pc;

  assign reg_we = in_exec & ~halted & ((op_cls == CLS_ALU) | (op_cls == CLS_LDI));

  instr_decoder #(.IW(IW)) u_dec (
    .ir      (ir),
    .alu_op  (dec_alu_op),
    .rd_addr (dec_rd),
    .rs_addr (dec_rs),
    .rt_addr (dec_rt),
    .imm     (dec_imm),
    .imm_sel (dec_imm_sel),
    .illegal (dec_illegal),
    .op_cls  (dec_cls)
  );

  // Fetch and execute state; halted freezes both until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= '0;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      if (in_fetch && !halted) ir <= mem_rdata;
      if (in_exec && !halted) begin
        case (op_cls)
          CLS_JMP:  pc <= PC_W'(imm);
          CLS_BEQZ: pc <= rs_zero ? PC_W'(imm) : pc + PC_W'(1);
          CLS_HALT: halted <= 1'b1;
          default:  pc <= pc + PC_W'(1);   // wraps naturally at 2^PC_W
        endcase
      end
    end
  end

  // Decoded fields hold from one decode to the next, so illegal stays
  // visible through execute and the following fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_op  <= '0;
      rd_addr <= '0;
      rs_addr <= '0;
      rt_addr <= '0;
      imm     <= '0;
      imm_sel <= 1'b0;
      illegal <= 1'b0;
      op_cls  <= CLS_NOP;
    end else if (in_decode) begin
      alu_op  <= dec_alu_op;
      rd_addr <= dec_rd;
      rs_addr <= dec_rs;
      rt_addr <= dec_rt;
      imm     <= dec_imm;
      imm_sel <= dec_imm_sel;
      illegal <= dec_illegal;
      op_cls  <= dec_cls;
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
module tb_fetch_decode_unit;

  localparam logic [3:0] S_F = 4'b0001;
  localparam logic [3:0] S_D = 4'b0010;
  localparam logic [3:0] S_E = 4'b0100;
  localparam logic [3:0] S_S = 4'b1000;

  logic        clk;
  logic        rst;
  logic [3:0]  state;
  logic [15:0] mem_rdata;
  logic        rs_zero;
  logic [7:0]  mem_addr, pc;
  logic [15:0] ir;
  logic [1:0]  alu_op;
  logic [3:0]  rd_addr, rs_addr, rt_addr;
  logic [7:0]  imm;
  logic        imm_sel, reg_we, halted, illegal, state_err;

  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr];

  fetch_decode_unit #(.PC_W(8), .IW(16)) dut (
    .clk(clk), .rst(rst), .state(state), .mem_rdata(mem_rdata), .rs_zero(rs_zero),
    .mem_addr(mem_addr), .pc(pc), .ir(ir), .alu_op(alu_op),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm),
    .imm_sel(imm_sel), .reg_we(reg_we), .halted(halted), .illegal(illegal),
    .state_err(state_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic        rsz;
    logic [3:0]  rd, rs, rt;
    logic [1:0]  alu;
    logic [7:0]  imm;
    logic        imm_sel, illegal, we;
    logic [7:0]  pc_next;
    logic        halted;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] model_pc;

  task automatic push(input string nm, input logic [31:0] val);
    exp_t e;
    e.nm = nm;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", nm, act);
    end else begin
      e = sb.pop_front();
      if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s (%s): got 0x%0h expected 0x%0h", nm, e.nm, act, e.val);
      end
    end
  endtask

  task automatic pc_chk(input string nm, input logic [31:0] exp_v, input logic [31:0] act);
    push(nm, exp_v);
    chk(nm, act);
  endtask

  // Present a phase, let it settle, then take the clock edge; returns 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    mem[model_pc] = v.instr;
    push("mem_addr", 32'(model_pc));
    push("ir",       32'(v.instr));
    push("rd",       32'(v.rd));
    push("rs",       32'(v.rs));
    push("rt",       32'(v.rt));
    push("alu_op",   32'(v.alu));
    push("imm",      32'(v.imm));
    push("imm_sel",  32'(v.imm_sel));
    push("illegal",  32'(v.illegal));
    push("reg_we_d", 32'(0));
    push("reg_we_e", 32'(v.we));
    push("pc",       32'(v.pc_next));
    push("halted",   32'(v.halted));
    push("illegal_hold", 32'(v.illegal));
    state = S_F;
    #1 chk("mem_addr", 32'(mem_addr));
    step();
    chk("ir", 32'(ir));
    state = S_D;
    step();
    chk("rd", 32'(rd_addr));
    chk("rs", 32'(rs_addr));
    chk("rt", 32'(rt_addr));
    chk("alu_op", 32'(alu_op));
    chk("imm", 32'(imm));
    chk("imm_sel", 32'(imm_sel));
    chk("illegal", 32'(illegal));
    chk("reg_we_d", 32'(reg_we));
    state = S_E;
    rs_zero = v.rsz;
    #1 chk("reg_we_e", 32'(reg_we));
    step();
    chk("pc", 32'(pc));
    chk("halted", 32'(halted));
    state = S_F;
    #1 chk("illegal_hold", 32'(illegal));
    model_pc = v.pc_next;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    //           instr     rsz rd    rs    rt    alu  imm    isel ill we pc_next halt
    vecs[0]  = '{16'h5A3C, 0, 4'hA, 4'h3, 4'hC, 2'd0, 8'h3C, 1, 0, 1, 8'h01, 0};
    vecs[1]  = '{16'h7010, 1, 4'h0, 4'h1, 4'h0, 2'd0, 8'h10, 0, 0, 0, 8'h10, 0};
    vecs[2]  = '{16'h1123, 0, 4'h1, 4'h2, 4'h3, 2'd0, 8'h23, 0, 0, 1, 8'h11, 0};
    vecs[3]  = '{16'h2456, 0, 4'h4, 4'h5, 4'h6, 2'd1, 8'h56, 0, 0, 1, 8'h12, 0};
    vecs[4]  = '{16'h3789, 0, 4'h7, 4'h8, 4'h9, 2'd2, 8'h89, 0, 0, 1, 8'h13, 0};
    vecs[5]  = '{16'h4ABC, 0, 4'hA, 4'hB, 4'hC, 2'd3, 8'hBC, 0, 0, 1, 8'h14, 0};
    vecs[6]  = '{16'hC000, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 1, 0, 8'h15, 0};
    vecs[7]  = '{16'h0000, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 0, 8'h16, 0};
    vecs[8]  = '{16'h60FF, 0, 4'h0, 4'hF, 4'hF, 2'd0, 8'hFF, 0, 0, 0, 8'hFF, 0};
    vecs[9]  = '{16'h0000, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 0};
    vecs[10] = '{16'h8000, 0, 4'h0, 4'h0, 4'h0, 2'd0, 8'h00, 0, 0, 0, 8'h00, 1};

    rst = 1'b0;
    state = 4'b0000;
    rs_zero = 1'b0;
    model_pc = 8'h00;

    // Reset values while rst is held low.
    #2;
    pc_chk("rst_pc", 0, 32'(pc));
    pc_chk("rst_ir", 0, 32'(ir));
    pc_chk("rst_mem_addr", 0, 32'(mem_addr));
    pc_chk("rst_halted", 0, 32'(halted));
    pc_chk("rst_imm_sel", 0, 32'(imm_sel));
    pc_chk("rst_state_err", 1, 32'(state_err));
    state = S_E;
    #1 pc_chk("rst_reg_we", 0, 32'(reg_we));
    pc_chk("rst_state_err_ok", 0, 32'(state_err));
    step();
    rst = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // After HALT: pc, ir and reg_we stay frozen over further rounds.
    mem[0] = 16'h1123;
    for (int r = 0; r < 3; r++) begin
      state = S_F;
      step();
      pc_chk("halt_ir", 32'h8000, 32'(ir));
      state = S_D;
      step();
      state = S_E;
      #1 pc_chk("halt_reg_we", 0, 32'(reg_we));
      step();
      pc_chk("halt_pc", 0, 32'(pc));
      pc_chk("halt_flag", 1, 32'(halted));
    end

    // Reset clears halted; then sleep between decode and execute.
    rst = 1'b0;
    #3 rst = 1'b1;
    pc_chk("rerst_halted", 0, 32'(halted));
    pc_chk("rerst_pc", 0, 32'(pc));
    mem[0] = 16'h5A3C;
    mem[1] = 16'h7010;
    state = S_F;
    step();
    state = S_D;
    step();
    for (int k = 0; k < 5; k++) begin
      state = S_S;
      #1 pc_chk("sleep_reg_we", 0, 32'(reg_we));
      step();
    end
    pc_chk("sleep_pc", 0, 32'(pc));
    pc_chk("sleep_ir", 32'h5A3C, 32'(ir));
    pc_chk("sleep_rd", 32'hA, 32'(rd_addr));
    pc_chk("sleep_imm_sel", 1, 32'(imm_sel));
    state = 4'b0101;
    #1 pc_chk("bad_state_err", 1, 32'(state_err));
    pc_chk("bad_reg_we", 0, 32'(reg_we));
    step();
    pc_chk("bad_pc", 0, 32'(pc));
    state = S_E;
    #1 pc_chk("e_state_err", 0, 32'(state_err));
    pc_chk("e_reg_we", 1, 32'(reg_we));
    step();
    pc_chk("e_pc", 1, 32'(pc));

    // BEQZ at 1 with rs_zero=0 falls through to 2.
    rs_zero = 1'b0;
    state = S_F;
    step();
    state = S_D;
    step();
    state = S_E;
    step();
    pc_chk("beqz_nt_pc", 2, 32'(pc));

    // Reset during execute of a JMP suppresses the jump.
    mem[2] = 16'h6042;
    state = S_F;
    step();
    pc_chk("jmp_ir", 32'h6042, 32'(ir));
    state = S_D;
    step();
    state = S_E;
    #1 rst = 1'b0;
    #1 pc_chk("jmp_rst_pc_async", 0, 32'(pc));
    step();
    pc_chk("jmp_rst_pc", 0, 32'(pc));
    rst = 1'b1;
    state = S_F;
    #1 pc_chk("jmp_rst_mem_addr", 0, 32'(mem_addr));
    step();
    pc_chk("jmp_rst_ir", 32'h5A3C, 32'(ir));

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 Parameter PC_W SHALL be: default 8; program counter and memory address width.
REQ-002 Parameter IW SHALL be: default 16; instruction width. Values other than 16 are unsupported.
REQ-003 Port clk SHALL be: input, 1 bit; rising-edge clock.
REQ-004 Port rst SHALL be: input, 1 bit; reset, asynchronous, active-low.
REQ-005 Port state SHALL be: input, 4 bits; one-hot phase from the sequencer (bit0 fetch, bit1 decode, bit2 execute, bit3 sleep).
REQ-006 Port mem_rdata SHALL be: input, IW bits; instruction memory read data, combinationally valid for the presented mem_addr.
REQ-007 Port rs_zero SHALL be: input, 1 bit; datapath flag, register rs equals zero.
REQ-008 Port mem_addr SHALL be: output, PC_W bits; instruction fetch address.
REQ-009 Port pc SHALL be: output, PC_W bits; current program counter.
REQ-010 Port ir SHALL be: output, IW bits; instruction register.
REQ-011 Port alu_op SHALL be: output, 2 bits; 0 ADD, 1 SUB, 2 AND, 3 OR.
REQ-012 Ports rd_addr, rs_addr, rt_addr SHALL be: outputs, 4 bits each; register addresses.
REQ-013 Port imm SHALL be: output, 8 bits; immediate field.
REQ-014 Port imm_sel SHALL be: output, 1 bit; write-back data is imm (LDI).
REQ-015 Port reg_we SHALL be: output, 1 bit; register-file write enable.
REQ-016 Port halted SHALL be: output, 1 bit; core stopped by HALT.
REQ-017 Port illegal SHALL be: output, 1 bit; decoded opcode is undefined.
REQ-018 Port state_err SHALL be: output, 1 bit; state input is not one-hot.

Function
REQ-019 Instruction format SHALL be [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt, [7:0] imm.
REQ-020 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LDI, 6 JMP, 7 BEQZ (compares rs), 8 HALT; 9-15 illegal.
REQ-021 mem_addr SHALL equal pc combinationally at all times.
REQ-022 On the clock edge ending a fetch cycle, ir SHALL load mem_rdata; ir SHALL hold in all other phases.
REQ-023 On the clock edge ending a decode cycle, the decoded fields (alu_op, rd/rs/rt_addr, imm, imm_sel, illegal) and an internal op class SHALL register from ir.
REQ-024 reg_we SHALL be 1 only while state is execute, the op is ADD, SUB, AND, OR or LDI, and halted is 0.
REQ-025 On the clock edge ending execute, pc SHALL update as follows: JMP -> imm; BEQZ with rs_zero=1 -> imm; HALT -> unchanged; all others -> pc+1 modulo 2^PC_W (wraps 0xFF to 0x00).
REQ-026 HALT in execute SHALL set halted=1; once set, pc, ir and reg_we SHALL freeze until reset.
REQ-027 Illegal opcodes SHALL execute as NOP (pc+1, reg_we=0), with illegal held high from decode until the next decode.
REQ-028 Sleep SHALL hold all registers; reg_we SHALL be 0.
REQ-029 A zero or multi-hot state SHALL be treated as sleep, and state_err SHALL be 1 combinationally for that cycle.
REQ-030 When imm_sel=1, rs_addr and rt_addr SHALL still present ir fields; the datapath ignores them.

Reset
REQ-031 On rst=0, the block SHALL asynchronously clear pc, ir, alu_op, the register addresses, imm, imm_sel, illegal, halted and the op class to 0; reg_we and state_err SHALL follow the combinational rules.
REQ-032 Reset asserted mid-execute SHALL suppress any pc update; the first fetch after release SHALL be at address 0.

Structure
REQ-033 Opcode constants, alu_op encodings and state bit indices SHALL reside in a shared package, cpu_pkg.
REQ-034 Decode SHALL be a combinational sub-module instr_decoder (ir in, fields out); sequencing and pc SHALL stay in the top.

Verification
REQ-035 Reset, then mem[0]=0x5A3C (LDI) through F, D, E -> ir=0x5A3C, rd=0xA, imm=0x3C, imm_sel=1, reg_we=1 in E only, pc=1 after E.
REQ-036 mem[1]=0x7010 (BEQZ), rs_zero=1 -> pc=0x10; repeat with rs_zero=0 -> pc=2.
REQ-037 pc=0xFF, NOP -> pc=0x00 after E.
REQ-038 Opcode 0xC000 -> illegal=1, reg_we=0, pc+1; opcode 0x8000 -> halted=1, pc frozen across 3 further F/D/E rounds.
REQ-039 Sleep inserted between D and E for 5 cycles -> no register change and reg_we=0; state=4'b0101 -> state_err=1, no update.
REQ-040 rst pulsed low during E of 0x6042 (JMP) -> pc=0, and the next fetch is at mem_addr=0.
